// File: rtl/d_module_led_status_ctrl_if.sv
// Keypad/password event pulses in, LED driver indicator and lockout status out.
interface d_module_led_status_ctrl_if;
  logic       key_press;
  logic       pass_ok;
  logic       pass_fail;
  logic [2:0] led_rgb;
  logic       rgb_toggle;
  logic       locked_out;
  logic [2:0] fail_cnt;

  // Event source (keypad / password checker side)
  modport master (
    output key_press,
    output pass_ok,
    output pass_fail,
    input  led_rgb,
    input  rgb_toggle,
    input  locked_out,
    input  fail_cnt
  );

  // Status controller side
  modport slave (
    input  key_press,
    input  pass_ok,
    input  pass_fail,
    output led_rgb,
    output rgb_toggle,
    output locked_out,
    output fail_cnt
  );
endinterface

// File: rtl/d_module_led_status_ctrl.sv
// Lock-status indicator: turns keypad/password events into timed LED phases
// and tracks consecutive wrong passwords, raising lockout at MAX_FAIL.
module d_module_led_status_ctrl #(
  parameter logic [27:0] TICK_DIV    = 28'd50000000,
  parameter logic [7:0]  ENTRY_TICKS = 8'd10,
  parameter logic [7:0]  OPEN_TICKS  = 8'd5,
  parameter logic [7:0]  ERR_TICKS   = 8'd3,
  parameter logic [7:0]  LOCK_TICKS  = 8'd30,
  parameter logic [2:0]  MAX_FAIL    = 3'd3
) (
  input  logic                        clk_in,
  input  logic                        idle,
  d_module_led_status_ctrl_if.slave   bus
);

  localparam int unsigned PRESC_W = 28;
  localparam int unsigned TICK_W  = 8;
  localparam int unsigned FAIL_W  = 3;
  localparam int unsigned LED_W   = 3;

  localparam logic [LED_W-1:0] LED_RED    = 3'b001;
  localparam logic [LED_W-1:0] LED_GREEN  = 3'b010;
  localparam logic [LED_W-1:0] LED_YELLOW = 3'b011;
  localparam logic [LED_W-1:0] LED_BLUE   = 3'b100;

  localparam logic [FAIL_W-1:0] FAIL_SAT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_ERROR   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [TICK_W-1:0]   tick_q,  tick_d;
  logic [FAIL_W-1:0]   fail_q,  fail_d;
  logic [LED_W-1:0]    led_q,   led_d;
  logic                tog_q,   tog_d;
  logic                lock_q,  lock_d;

  logic                tick_c;
  logic                expired_c;
  logic                reload_c;
  logic [TICK_W-1:0]   limit_c;
  logic [FAIL_W-1:0]   fail_inc_c;

  // Duration of the current timed state, in ticks
  always_comb begin
    limit_c = 8'd1;
    case (state_q)
      ST_ENTRY:   limit_c = ENTRY_TICKS;
      ST_OPEN:    limit_c = OPEN_TICKS;
      ST_ERROR:   limit_c = ERR_TICKS;
      ST_LOCKOUT: limit_c = LOCK_TICKS;
      default:    limit_c = 8'd1;
    endcase
  end

  // Next state, failure counter and timebase
  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    presc_d    = presc_q;
    tick_d     = tick_q;
    reload_c   = 1'b0;
    tick_c     = (presc_q == (TICK_DIV - 28'd1));
    expired_c  = tick_c && (tick_q == (limit_c - 8'd1));
    fail_inc_c = (fail_q == FAIL_SAT) ? FAIL_SAT : FAIL_W'(fail_q + 3'd1);

    if (tick_c) begin
      presc_d = '0;
      tick_d  = TICK_W'(tick_q + 8'd1);
    end else begin
      presc_d = PRESC_W'(presc_q + 28'd1);
    end

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (bus.pass_fail) begin
          fail_d  = fail_inc_c;
          state_d = (fail_inc_c == MAX_FAIL) ? ST_LOCKOUT : ST_ERROR;
        end else if (bus.pass_ok) begin
          fail_d  = '0;
          state_d = ST_OPEN;
        end else if (bus.key_press) begin
          state_d  = ST_ENTRY;
          reload_c = (state_q == ST_ENTRY);
        end else if (state_q == ST_ENTRY && expired_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_OPEN, ST_ERROR: begin
        if (expired_c) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (expired_c) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every phase starts its timing from zero
    if (state_d != state_q || reload_c) begin
      presc_d = '0;
      tick_d  = '0;
    end
  end

  // Moore output decode, registered alongside the state
  always_comb begin
    led_d  = LED_BLUE;
    tog_d  = 1'b0;
    lock_d = 1'b0;
    case (state_d)
      ST_IDLE:    led_d = LED_BLUE;
      ST_ENTRY:   led_d = LED_YELLOW;
      ST_OPEN:    led_d = LED_GREEN;
      ST_ERROR: begin
        led_d = LED_RED;
        tog_d = 1'b1;
      end
      ST_LOCKOUT: begin
        led_d  = LED_RED;
        tog_d  = 1'b1;
        lock_d = 1'b1;
      end
      default:    led_d = LED_BLUE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (idle) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tick_q  <= '0;
      fail_q  <= '0;
      led_q   <= LED_BLUE;
      tog_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      fail_q  <= fail_d;
      led_q   <= led_d;
      tog_q   <= tog_d;
      lock_q  <= lock_d;
    end
  end

  assign bus.led_rgb    = led_q;
  assign bus.rgb_toggle = tog_q;
  assign bus.locked_out = lock_q;
  assign bus.fail_cnt   = fail_q;

endmodule

// File: tb/tb_d_module_led_status_ctrl.sv
// Scoreboard bench: a countdown-based reference model predicts the indicator
// after every clock edge; a monitor on the falling edge compares the DUT.
module tb_d_module_led_status_ctrl;

  localparam int TD      = 4;
  localparam int N_ENTRY = 10;
  localparam int N_OPEN  = 5;
  localparam int N_ERR   = 3;
  localparam int N_LOCK  = 30;
  localparam int MAXF    = 3;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_OPEN  = 2;
  localparam int M_ERROR = 3;
  localparam int M_LOCK  = 4;

  typedef struct {
    logic [2:0] led;
    logic       tog;
    logic       lk;
    logic [2:0] fc;
  } exp_t;

  logic clk_in = 1'b0;
  logic idle;
  always #5 clk_in = ~clk_in;

  d_module_led_status_ctrl_if bus ();

  d_module_led_status_ctrl #(
    .TICK_DIV   (28'd4),
    .ENTRY_TICKS(8'd10),
    .OPEN_TICKS (8'd5),
    .ERR_TICKS  (8'd3),
    .LOCK_TICKS (8'd30),
    .MAX_FAIL   (3'd3)
  ) u_dut (
    .clk_in(clk_in),
    .idle  (idle),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: state, cycles remaining in a timed phase, failure count
  int m_state = M_IDLE;
  int m_rem   = 0;
  int m_fail  = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.fc = 3'(m_fail);
    e.tog = 1'b0;
    e.lk  = 1'b0;
    case (m_state)
      M_ENTRY: e.led = 3'b011;
      M_OPEN:  e.led = 3'b010;
      M_ERROR: begin e.led = 3'b001; e.tog = 1'b1; end
      M_LOCK:  begin e.led = 3'b001; e.tog = 1'b1; e.lk = 1'b1; end
      default: e.led = 3'b100;
    endcase
    return e;
  endfunction

  task automatic model_edge(input bit rst, input bit kp, input bit ok, input bit fl);
    if (rst) begin
      m_state = M_IDLE; m_rem = 0; m_fail = 0;
    end else if (m_state == M_IDLE || m_state == M_ENTRY) begin
      if (fl) begin
        m_fail = (m_fail >= 7) ? 7 : m_fail + 1;
        if (m_fail == MAXF) begin m_state = M_LOCK;  m_rem = N_LOCK * TD; end
        else                begin m_state = M_ERROR; m_rem = N_ERR * TD;  end
      end else if (ok) begin
        m_state = M_OPEN; m_rem = N_OPEN * TD; m_fail = 0;
      end else if (kp) begin
        m_state = M_ENTRY; m_rem = N_ENTRY * TD;
      end else if (m_state == M_ENTRY) begin
        m_rem--;
        if (m_rem == 0) m_state = M_IDLE;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_state == M_LOCK) m_fail = 0;
        m_state = M_IDLE;
      end
    end
  endtask

  // One clock: present inputs, model the edge, queue the expected outputs
  task automatic step(input bit rst, input bit kp, input bit ok, input bit fl);
    idle = rst;
    bus.key_press = kp;
    bus.pass_ok   = ok;
    bus.pass_fail = fl;
    @(posedge clk_in);
    model_edge(rst, kp, ok, fl);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic wait_model_idle();
    int n = 0;
    while (m_state != M_IDLE && n < 400) begin
      step(0, 0, 0, 0);
      n++;
    end
    chk("return_to_idle_bound", int'(m_state == M_IDLE), 1);
  endtask

  // Counts consecutive cycles the DUT holds a colour (sel=0) or lockout (sel=1)
  task automatic measure(input int sel, input logic [2:0] col, input int req,
                         input bit noise, input string name);
    int n = 0;
    while (n < 300 && ((sel == 0) ? (bus.led_rgb === col) : (bus.locked_out === 1'b1))) begin
      n++;
      if (noise) step(0, ($urandom % 3) == 0, ($urandom % 5) == 0, 0);
      else       step(0, 0, 0, 0);
    end
    chk(name, n, req);
  endtask

  // Monitor: every cycle the DUT presents a fresh indicator value
  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_led_rgb",    int'(bus.led_rgb),    int'(e.led));
      chk("sb_rgb_toggle", int'(bus.rgb_toggle), int'(e.tog));
      chk("sb_locked_out", int'(bus.locked_out), int'(e.lk));
      chk("sb_fail_cnt",   int'(bus.fail_cnt),   int'(e.fc));
    end
  end

  initial begin
    idle = 1'b1;
    bus.key_press = 1'b0;
    bus.pass_ok   = 1'b0;
    bus.pass_fail = 1'b0;

    // Reset
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_led",  int'(bus.led_rgb), 4);
    chk("reset_tog",  int'(bus.rgb_toggle), 0);
    chk("reset_lock", int'(bus.locked_out), 0);
    chk("reset_fail", int'(bus.fail_cnt), 0);

    // Single key -> ENTRY for 40 cycles
    step(0, 1, 0, 0);
    measure(0, 3'b011, 40, 0, "entry_timeout_len");
    chk("entry_back_to_blue", int'(bus.led_rgb), 4);

    // Repeated keys keep ENTRY alive
    step(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 29; c++) begin
        step(0, 0, 0, 0);
        chk("entry_held", int'(bus.led_rgb), 3);
      end
      step(0, 1, 0, 0);
    end
    measure(0, 3'b011, 40, 0, "entry_after_last_key");

    // One failure, then pass_ok -> OPEN with fail_cnt cleared
    step(0, 0, 0, 1);
    chk("fail1_cnt", int'(bus.fail_cnt), 1);
    wait_model_idle();
    step(0, 0, 1, 0);
    chk("open_fail_cleared", int'(bus.fail_cnt), 0);
    measure(0, 3'b010, 20, 0, "open_len");

    // Three failures -> two ERROR phases then LOCKOUT
    step(0, 0, 0, 1);
    chk("err1_cnt", int'(bus.fail_cnt), 1);
    measure(0, 3'b001, 12, 0, "err1_len");
    step(0, 0, 0, 1);
    chk("err2_cnt", int'(bus.fail_cnt), 2);
    chk("err2_tog", int'(bus.rgb_toggle), 1);
    measure(0, 3'b001, 12, 0, "err2_len");
    step(0, 0, 0, 1);
    measure(1, 3'b000, 120, 1, "lockout_len");
    chk("post_lock_fail", int'(bus.fail_cnt), 0);
    chk("post_lock_led", int'(bus.led_rgb), 4);

    // Coincident pass_ok and pass_fail counts as failure
    step(0, 0, 1, 1);
    chk("coinc_led", int'(bus.led_rgb), 1);
    chk("coinc_fail", int'(bus.fail_cnt), 1);
    wait_model_idle();

    // Reset mid-lockout
    step(0, 0, 0, 1); wait_model_idle();
    step(0, 0, 0, 1);
    chk("lock_entered", int'(bus.locked_out), 1);
    for (int c = 0; c < 49; c++) step(0, 1, 1, 0);
    step(1, 0, 0, 0);
    chk("rst_lock_led",  int'(bus.led_rgb), 4);
    chk("rst_lock_lk",   int'(bus.locked_out), 0);
    chk("rst_lock_fail", int'(bus.fail_cnt), 0);

    // Randomised event traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 200) == 0, ($urandom % 10) == 0,
           ($urandom % 30) == 0, ($urandom % 20) == 0);
    end
    step(0, 0, 0, 0);

    // Drain the scoreboard
    @(negedge clk_in);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_module_led_status_ctrl.md
Name: d_module_led_status_ctrl

Overview:
Lock-status indicator controller. It sits directly upstream of the RGB LED driver and supplies that driver's colour code (led_rgb) and blink request (rgb_toggle). A Moore state machine converts keypad and password-check event pulses into timed indicator phases: idle, entry, open, error and lockout. It also counts consecutive wrong passwords and asserts a lockout flag back to the keypad logic.

Parameters:
TICK_DIV, 28'd50000000, clk_in cycles per timebase tick (1 s at 50 MHz); minimum 2.
ENTRY_TICKS, 8'd10, ticks of no key activity before ENTRY times out to IDLE.
OPEN_TICKS, 8'd5, ticks GREEN is shown after a correct password.
ERR_TICKS, 8'd3, ticks blinking RED is shown after a wrong password.
LOCK_TICKS, 8'd30, lockout duration in ticks.
MAX_FAIL, 3'd3, consecutive failures that trigger lockout; range 1..7.

Ports:
clk_in  input  1  system clock; all logic on the rising edge.
idle  input  1  synchronous, active-high reset.
key_press  input  1  one-cycle pulse per keypad key accepted.
pass_ok  input  1  one-cycle pulse: entered password correct.
pass_fail  input  1  one-cycle pulse: entered password wrong.
led_rgb  output  3  colour code to LED driver: OFF 000, RED 001, GREEN 010, YELLOW 011, BLUE 100, WHITE 111.
rgb_toggle  output  1  1 = LED driver blinks led_rgb; 0 = steady.
locked_out  output  1  1 while in LOCKOUT; keypad ignores keys.
fail_cnt  output  3  current consecutive-failure count.

Behaviour:
- States: IDLE, ENTRY, OPEN, ERROR, LOCKOUT. Outputs are decoded from the registered state only (Moore).
- Output decode:
  - IDLE: BLUE, toggle 0.
  - ENTRY: YELLOW, toggle 0.
  - OPEN: GREEN, toggle 0.
  - ERROR: RED, toggle 1.
  - LOCKOUT: RED, toggle 1, locked_out 1.
- locked_out is 0 in every state except LOCKOUT.
- Reset (idle=1 at a clock edge): state IDLE, prescaler 0, tick counter 0, fail_cnt 0. Outputs from the next cycle: led_rgb=100, rgb_toggle=0, locked_out=0. Reset overrides all inputs and takes effect from any state, including mid-LOCKOUT.
- Timebase: the prescaler counts 0..TICK_DIV-1 and produces one tick per wrap. The tick counter counts ticks. Both clear on every state change and on every timer reload.
- A timed state lasting N ticks changes state exactly N*TICK_DIV clk_in cycles after its first cycle.
- Failure path, for any pass_fail accepted:
  - fail_cnt increments (saturates at 7).
  - If the new value equals MAX_FAIL, go to LOCKOUT; otherwise go to ERROR.
- Input priority when inputs coincide: pass_fail > pass_ok > key_press. Coincident pass_ok and pass_fail is treated as a failure.
- IDLE:
  - key_press -> ENTRY.
  - pass_ok -> OPEN.
  - pass_fail -> failure path.
- ENTRY:
  - key_press reloads the timer.
  - ENTRY_TICKS elapsed with no key_press -> IDLE; fail_cnt is unchanged.
  - pass_ok -> OPEN.
  - pass_fail -> failure path.
- OPEN:
  - fail_cnt clears on entry.
  - All inputs are ignored.
  - After OPEN_TICKS -> IDLE.
- ERROR:
  - All inputs are ignored.
  - After ERR_TICKS -> IDLE.
- LOCKOUT:
  - All inputs are ignored.
  - After LOCK_TICKS -> IDLE, and fail_cnt clears on the same edge.
- Latency: an event pulse at edge k changes the state, and therefore the outputs, at edge k+1.
- Width rules: tick counters are 8 bits; the prescaler is 28 bits. A parameter value of 0 ticks is illegal.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, ENTRY_TICKS=10, OPEN_TICKS=5, ERR_TICKS=3, LOCK_TICKS=30, MAX_FAIL=3.
1. Assert idle for 2 cycles, then release -> led_rgb=100, rgb_toggle=0, locked_out=0, fail_cnt=0.
2. Single key_press, no further input -> led_rgb=011 for exactly 40 cycles, then 100.
3. key_press, then key_press every 30 cycles 4 times -> stays 011 throughout; returns to 100 40 cycles after the last key.
4. pass_ok from IDLE after one earlier failure -> led_rgb=010 for exactly 20 cycles, fail_cnt=0, then 100.
5. Three pass_fail pulses, each issued after the system returns to IDLE:
   - First two: led_rgb=001, rgb_toggle=1 for 12 cycles each; fail_cnt goes 1, then 2.
   - Third: locked_out=1 for exactly 120 cycles, key_press and pass_ok ignored during it; then fail_cnt=0 and led_rgb=100.
6. pass_ok and pass_fail asserted in the same cycle in IDLE -> ERROR with fail_cnt=1. Separately, assert idle 50 cycles into LOCKOUT -> next cycle IDLE, locked_out=0, fail_cnt=0.
